// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-requester shift arbiter:
// datapath widths and the result-register FSM states.
package shift_arbiter_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/barrel_shifter.sv
// Combinational 8-bit barrel shifter: left zero-fill, right logical or
// arithmetic (sign-replicating) depending on AL.
module barrel_shifter
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               LR,
    input  logic               AL,
    output logic [DATA_W-1:0]  dout
);

    always_comb begin
        if (LR) begin
            dout = din << shamt;
        end else if (AL) begin
            dout = $unsigned($signed(din) >>> shamt);
        end else begin
            dout = din >> shamt;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters,
// with a single registered result slot and saturating per-requester grant counts.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter int RR_INIT = 0,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [DATA_W-1:0]  req0_din,
    input  logic [SHAMT_W-1:0] req0_shamt,
    input  logic               req0_lr,
    input  logic               req0_al,

    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [DATA_W-1:0]  req1_din,
    input  logic [SHAMT_W-1:0] req1_shamt,
    input  logic               req1_lr,
    input  logic               req1_al,

    output logic               res_valid,
    input  logic               res_ready,
    output logic [DATA_W-1:0]  res_dout,
    output logic               res_id,

    output logic [CNT_W-1:0]   gnt_cnt0,
    output logic [CNT_W-1:0]   gnt_cnt1
);

    state_t             state, state_nxt;
    logic               prio;
    logic               can_grant;
    logic               gnt0, gnt1;
    logic [DATA_W-1:0]  op_din, shift_out;
    logic [SHAMT_W-1:0] op_shamt;
    logic               op_lr, op_al;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        can_grant = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        if (rst_n) begin
            // HOLD can drain and refill the result register in the same cycle.
            can_grant = (state == IDLE) || res_ready;
            gnt0      = can_grant && req0_valid && (!req1_valid || !prio);
            gnt1      = can_grant && req1_valid && (!req0_valid ||  prio);
            if (gnt0 || gnt1) begin
                state_nxt = HOLD;
            end else if (state == HOLD && res_ready) begin
                state_nxt = IDLE;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign res_valid  = (state == HOLD);

    assign op_din   = gnt1 ? req1_din   : req0_din;
    assign op_shamt = gnt1 ? req1_shamt : req0_shamt;
    assign op_lr    = gnt1 ? req1_lr    : req0_lr;
    assign op_al    = gnt1 ? req1_al    : req0_al;

    barrel_shifter u_shifter (
        .din   (op_din),
        .shamt (op_shamt),
        .LR    (op_lr),
        .AL    (op_al),
        .dout  (shift_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_dout <= '0;
            res_id   <= 1'b0;
            prio     <= RR_INIT[0];
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (gnt0 || gnt1) begin
                res_dout <= shift_out;
                res_id   <= gnt1;
                prio     <= gnt0;   // priority passes to the requester not served
            end
            if (gnt0 && gnt_cnt0 != '1) begin
                gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            end
            if (gnt1 && gnt_cnt1 != '1) begin
                gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed vectors, hand-written
// back-pressure/saturation/reset sequences and randomized traffic vs. a reference model.
module tb_shift_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req0_lr, req0_al;
    logic [7:0] req0_din;
    logic [2:0] req0_shamt;
    logic       req1_valid, req1_lr, req1_al;
    logic [7:0] req1_din;
    logic [2:0] req1_shamt;
    logic       res_ready;

    logic       req0_ready, req1_ready, res_valid, res_id;
    logic [7:0] res_dout, gnt_cnt0, gnt_cnt1;

    logic       c2_req0_ready, c2_req1_ready, c2_res_valid, c2_res_id;
    logic [7:0] c2_res_dout;
    logic [1:0] c2_gnt_cnt0, c2_gnt_cnt1;

    always #5 clk = ~clk;

    shift_arbiter #(.RR_INIT(0), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_din(req0_din),
        .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_din(req1_din),
        .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
        .res_valid(res_valid), .res_ready(res_ready), .res_dout(res_dout), .res_id(res_id),
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
    );

    shift_arbiter #(.RR_INIT(0), .CNT_W(2)) dut_c2 (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(c2_req0_ready), .req0_din(req0_din),
        .req0_shamt(req0_shamt), .req0_lr(req0_lr), .req0_al(req0_al),
        .req1_valid(req1_valid), .req1_ready(c2_req1_ready), .req1_din(req1_din),
        .req1_shamt(req1_shamt), .req1_lr(req1_lr), .req1_al(req1_al),
        .res_valid(c2_res_valid), .res_ready(res_ready), .res_dout(c2_res_dout), .res_id(c2_res_id),
        .gnt_cnt0(c2_gnt_cnt0), .gnt_cnt1(c2_gnt_cnt1)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: result slot contents, priority and grant totals.
    bit         m_full = 1'b0;
    logic [7:0] m_dout = 8'h00;
    bit         m_id   = 1'b0;
    bit         m_prio = 1'b0;
    int         m_cnt0 = 0, m_cnt1 = 0;

    typedef struct {
        logic       v0;
        logic [7:0] d0;
        logic [2:0] s0;
        logic       lr0, al0;
        logic       v1;
        logic [7:0] d1;
        logic [2:0] s1;
        logic       lr1, al1;
        logic [7:0] exp_dout;
        logic       exp_id;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] din, input logic [2:0] sh,
                                             input logic lr, input logic al);
        int v;
        int p;
        p = 1 << sh;
        if (lr) begin
            v = (int'(din) * p) % 256;
        end else if (al && din >= 8'd128) begin
            v = int'(din) - 256;
            v = (v - (p - 1)) / p;   // floor division of a negative value
            v = v + 256;
        end else begin
            v = int'(din) / p;
        end
        return 8'(v);
    endfunction

    function automatic int sat(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    // One clock: predict readies from current inputs, then check registered outputs.
    task automatic cycle();
        bit         can, g0, g1;
        logic [7:0] nd;
        @(negedge clk);
        can = rst_n && (!m_full || res_ready);
        g0  = can && req0_valid && (!req1_valid || !m_prio);
        g1  = can && req1_valid && !g0;
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        nd = g1 ? ref_shift(req1_din, req1_shamt, req1_lr, req1_al)
                : ref_shift(req0_din, req0_shamt, req0_lr, req0_al);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            m_full = 1'b0; m_dout = 8'h00; m_id = 1'b0; m_prio = 1'b0;
            m_cnt0 = 0;    m_cnt1 = 0;
        end else if (g0 || g1) begin
            m_full = 1'b1; m_dout = nd; m_id = g1; m_prio = g0;
            if (g0) m_cnt0++;
            if (g1) m_cnt1++;
        end else if (m_full && res_ready) begin
            m_full = 1'b0;
        end
        check("res_valid", res_valid, m_full);
        check("res_dout", res_dout, m_dout);
        check("res_id", res_id, m_id);
        check("gnt_cnt0", gnt_cnt0, (m_cnt0 > 255) ? 255 : m_cnt0);
        check("gnt_cnt1", gnt_cnt1, (m_cnt1 > 255) ? 255 : m_cnt1);
        check("c2_gnt_cnt0", c2_gnt_cnt0, (m_cnt0 > 3) ? 3 : m_cnt0);
        check("c2_gnt_cnt1", c2_gnt_cnt1, (m_cnt1 > 3) ? 3 : m_cnt1);
    endtask

    task automatic randomize_operands();
        req0_din = 8'($urandom); req0_shamt = 3'($urandom);
        req0_lr  = 1'($urandom); req0_al    = 1'($urandom);
        req1_din = 8'($urandom); req1_shamt = 3'($urandom);
        req1_lr  = 1'($urandom); req1_al    = 1'($urandom);
    endtask

    initial begin
        logic [7:0] held_dout;
        logic       held_id;

        rst_n = 1'b0; res_ready = 1'b0;
        req0_valid = 1'b0; req0_din = '0; req0_shamt = '0; req0_lr = 1'b0; req0_al = 1'b0;
        req1_valid = 1'b0; req1_din = '0; req1_shamt = '0; req1_lr = 1'b0; req1_al = 1'b0;

        vecs[0] = '{1'b1, 8'b10101010, 3'd2, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'b10101000, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'b10101010, 3'd2, 1'b0, 1'b0, 8'b00101010, 1'b1};
        vecs[2] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'b10101010, 3'd2, 1'b0, 1'b1, 8'b11101010, 1'b1};
        vecs[3] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'b10101010, 3'd7, 1'b0, 1'b1, 8'b11111111, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'b10101010, 3'd0, 1'b0, 1'b1, 8'b10101010, 1'b1};

        // Reset state, with a request present to show readies stay low.
        req0_valid = 1'b1;
        cycle();
        cycle();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        cycle();

        // Directed single-request vectors, each followed by a drain cycle.
        res_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            req0_valid = vecs[i].v0; req0_din = vecs[i].d0; req0_shamt = vecs[i].s0;
            req0_lr    = vecs[i].lr0; req0_al = vecs[i].al0;
            req1_valid = vecs[i].v1; req1_din = vecs[i].d1; req1_shamt = vecs[i].s1;
            req1_lr    = vecs[i].lr1; req1_al = vecs[i].al1;
            cycle();
            check("vec_valid", res_valid, 1'b1);
            check("vec_dout", res_dout, vecs[i].exp_dout);
            check("vec_id", res_id, vecs[i].exp_id);
            req0_valid = 1'b0; req1_valid = 1'b0;
            cycle();
            check("vec_drained", res_valid, 1'b0);
        end

        // Both valid with res_ready=1: grants alternate starting at requester 0.
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            randomize_operands();
            cycle();
            check("alt_id", res_id, i % 2);
            check("alt_valid", res_valid, 1'b1);
        end

        // Back-pressure: result frozen, no grants, operand changes ignored.
        res_ready = 1'b0;
        held_dout = res_dout;
        held_id   = res_id;
        for (int i = 0; i < 5; i++) begin
            randomize_operands();
            cycle();
            check("stall_dout", res_dout, held_dout);
            check("stall_id", res_id, held_id);
            check("stall_r0", req0_ready, 1'b0);
            check("stall_r1", req1_ready, 1'b0);
        end
        res_ready = 1'b1;
        cycle();
        check("resume_id", res_id, 1'b0);

        // Counter saturation from a clean start.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        req1_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randomize_operands();
            cycle();
        end
        check("sat_c2_cnt0", c2_gnt_cnt0, 2'd3);
        check("sat_cnt0", gnt_cnt0, 8'd5);

        // Reset while a result is held discards it without a handshake.
        res_ready  = 1'b0;
        req1_valid = 1'b1;
        check("pre_rst_hold", res_valid, 1'b1);
        rst_n = 1'b0;
        cycle();
        check("rst_hold_valid", res_valid, 1'b0);
        check("rst_hold_cnt0", gnt_cnt0, 8'd0);
        check("rst_hold_c2cnt0", c2_gnt_cnt0, 2'd0);
        rst_n = 1'b1;

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            rst_n      = ($urandom_range(0, 49) != 0);
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            res_ready  = ($urandom_range(0, 3) != 0);
            randomize_operands();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
